wr_addr_s_stp: RTL and testbench

- Write-side controller for the S (coefficient) memory.
- On an STP instruction it accepts a polynomial's degree and then streams its coefficients over a valid/ready handshake.
- It writes the degree into the N memory and the coefficients into S at `poly_id*(max_degree+1)+k`.
- It is the producer end of the S memory that EVP/EVB read through the S read-address mux.

---
 rtl/wr_addr_s_stp.sv | 142 ++++++++++++++
 tb/tb_wr_addr_s_stp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wr_addr_s_stp.sv
// Write-side controller for the S coefficient memory: on STP it records the degree in N and
// streams the coefficients into slot poly_id of S over a valid/ready handshake.
module wr_addr_s_stp #(
   parameter int unsigned SSize     = 88,
   parameter int unsigned NPoly     = 8,
   parameter int unsigned MaxDegree = 10,
   parameter int unsigned WordSize  = 16,
   localparam int unsigned Aw = (SSize <= 1) ? 1 : $clog2(SSize),
   localparam int unsigned Pw = (NPoly <= 1) ? 1 : $clog2(NPoly),
   localparam int unsigned Dw = (MaxDegree + 1 <= 1) ? 1 : $clog2(MaxDegree + 1)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic [7:0]          i_instr,
   input  logic [Dw-1:0]       i_degree_in,
   input  logic [WordSize-1:0] i_din,
   input  logic                i_din_valid,
   output logic                o_din_ready,
   output logic                o_wr_en_s,
   output logic [Aw-1:0]       o_wr_addr_s,
   output logic [WordSize-1:0] o_wr_data_s,
   output logic                o_wr_en_n,
   output logic [Pw-1:0]       o_wr_addr_n,
   output logic [Dw-1:0]       o_wr_data_n,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err
);

   typedef enum logic [2:0] {StIdle, StWrN, StWrS, StDone, StErr} state_e;

   state_e              r_state;
   logic [Pw-1:0]       r_poly;
   logic [Dw-1:0]       r_degree;
   logic [Aw-1:0]       r_base;
   logic [Dw-1:0]       r_k;
   logic                r_din_ready;
   logic                r_wr_en_s;
   logic [Aw-1:0]       r_wr_addr_s;
   logic [WordSize-1:0] r_wr_data_s;
   logic                r_wr_en_n;
   logic [Pw-1:0]       r_wr_addr_n;
   logic [Dw-1:0]       r_wr_data_n;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   logic [Pw-1:0] w_poly_id;
   logic          w_accept;

   assign w_poly_id = i_instr[Pw+1:2];
   assign w_accept  = i_din_valid & r_din_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_poly      <= '0;
         r_degree    <= '0;
         r_base      <= '0;
         r_k         <= '0;
         r_din_ready <= 1'b0;
         r_wr_en_s   <= 1'b0;
         r_wr_addr_s <= '0;
         r_wr_data_s <= '0;
         r_wr_en_n   <= 1'b0;
         r_wr_addr_n <= '0;
         r_wr_data_n <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         // Strobes default low; address/data registers hold their last value.
         r_wr_en_s <= 1'b0;
         r_wr_en_n <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_start && (i_instr[1:0] == 2'b00)) begin
                  r_busy <= 1'b1;
                  if (i_degree_in <= Dw'(MaxDegree)) begin
                     r_poly   <= w_poly_id;
                     r_degree <= i_degree_in;
                     r_base   <= Aw'(w_poly_id) * Aw'(MaxDegree + 1);
                     r_k      <= '0;
                     r_state  <= StWrN;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= StErr;
                  end
               end
            end
            StWrN: begin
               r_wr_en_n   <= 1'b1;
               r_wr_addr_n <= r_poly;
               r_wr_data_n <= r_degree;
               r_din_ready <= 1'b1;
               r_state     <= StWrS;
            end
            StWrS: begin
               if (w_accept) begin
                  r_wr_en_s   <= 1'b1;
                  r_wr_addr_s <= r_base + Aw'(r_k);
                  r_wr_data_s <= i_din;
                  r_k         <= r_k + 1'b1;
                  if (r_k == r_degree) begin
                     r_din_ready <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= StDone;
                  end
               end
            end
            StDone: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            StErr: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               r_busy      <= 1'b0;
               r_din_ready <= 1'b0;
               r_state     <= StIdle;
            end
         endcase
      end
   end

   assign o_din_ready = r_din_ready;
   assign o_wr_en_s   = r_wr_en_s;
   assign o_wr_addr_s = r_wr_addr_s;
   assign o_wr_data_s = r_wr_data_s;
   assign o_wr_en_n   = r_wr_en_n;
   assign o_wr_addr_n = r_wr_addr_n;
   assign o_wr_data_n = r_wr_data_n;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;

endmodule

// File: tb/tb_wr_addr_s_stp.sv
// Directed bench for wr_addr_s_stp: outputs are sampled 1 ns after each rising edge.
module tb_wr_addr_s_stp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  instr;
   logic [3:0]  degree_in;
   logic [15:0] din;
   logic        din_valid;
   logic        din_ready;
   logic        wr_en_s;
   logic [6:0]  wr_addr_s;
   logic [15:0] wr_data_s;
   logic        wr_en_n;
   logic [2:0]  wr_addr_n;
   logic [3:0]  wr_data_n;
   logic        busy;
   logic        done;
   logic        err;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   wr_addr_s_stp dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_instr     (instr),
      .i_degree_in (degree_in),
      .i_din       (din),
      .i_din_valid (din_valid),
      .o_din_ready (din_ready),
      .o_wr_en_s   (wr_en_s),
      .o_wr_addr_s (wr_addr_s),
      .o_wr_data_s (wr_data_s),
      .o_wr_en_n   (wr_en_n),
      .o_wr_addr_n (wr_addr_n),
      .o_wr_data_n (wr_data_n),
      .o_busy      (busy),
      .o_done      (done),
      .o_err       (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rdy"}, din_ready, 0);
      chk({tag, "_wen_s"}, wr_en_s, 0);
      chk({tag, "_wen_n"}, wr_en_n, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; instr = 8'h00; degree_in = 4'd0;
      din = 16'h0000; din_valid = 1'b0;
      tick(); tick();
      chk_idle("rst");
      chk("rst_addr_s", wr_addr_s, 0);
      chk("rst_data_s", wr_data_s, 0);
      rst_n = 1'b1;
      tick();

      // Basic STP: poly 3, degree 2 -> S addresses 33..35
      start = 1'b1; instr = 8'h0C; degree_in = 4'd2;
      tick();
      start = 1'b0;
      chk("b_busy", busy, 1);
      chk("b_wen_n0", wr_en_n, 0);
      chk("b_rdy0", din_ready, 0);
      tick();
      chk("b_wen_n", wr_en_n, 1);
      chk("b_addr_n", wr_addr_n, 3);
      chk("b_data_n", wr_data_n, 2);
      chk("b_rdy", din_ready, 1);
      for (int i = 0; i < 3; i++) begin
         din_valid = 1'b1; din = 16'(17 * (i + 1));
         tick();
         chk("b_wen_s", wr_en_s, 1);
         chk("b_addr_s", wr_addr_s, 33 + i);
         chk("b_data_s", wr_data_s, 17 * (i + 1));
         chk("b_done", done, (i == 2) ? 1 : 0);
         chk("b_rdy_s", din_ready, (i == 2) ? 0 : 1);
      end
      din_valid = 1'b0;
      tick();
      chk("b_done_end", done, 0);
      chk("b_busy_end", busy, 0);
      chk("b_wen_s_end", wr_en_s, 0);

      // Bubbles: poly 7, degree 10 -> addresses 77..87; start mid-load ignored
      start = 1'b1; instr = 8'h1C; degree_in = 4'd10;
      tick();
      start = 1'b0;
      tick();
      chk("v_wen_n", wr_en_n, 1);
      chk("v_addr_n", wr_addr_n, 7);
      chk("v_data_n", wr_data_n, 10);
      for (int i = 0; i <= 10; i++) begin
         din_valid = 1'b1; din = 16'h0100 + 16'(i);
         tick();
         chk("v_wen_s", wr_en_s, 1);
         chk("v_addr_s", wr_addr_s, 77 + i);
         chk("v_data_s", wr_data_s, 32'h100 + i);
         chk("v_done", done, (i == 10) ? 1 : 0);
         if (i < 10) begin
            din_valid = 1'b0;
            if (i == 4) begin
               start = 1'b1; instr = 8'h04; degree_in = 4'd1;
            end
            tick();
            start = 1'b0;
            chk("v_bub_wen_s", wr_en_s, 0);
            chk("v_bub_wen_n", wr_en_n, 0);
            chk("v_bub_hold", wr_addr_s, 77 + i);
            chk("v_bub_rdy", din_ready, 1);
         end
      end
      din_valid = 1'b0;
      tick();
      chk_idle("v_end");

      // Degree 0 at poly 0
      start = 1'b1; instr = 8'h00; degree_in = 4'd0;
      tick();
      start = 1'b0;
      tick();
      chk("z_wen_n", wr_en_n, 1);
      chk("z_addr_n", wr_addr_n, 0);
      din_valid = 1'b1; din = 16'hBEEF;
      tick();
      din_valid = 1'b0;
      chk("z_wen_s", wr_en_s, 1);
      chk("z_addr_s", wr_addr_s, 0);
      chk("z_data_s", wr_data_s, 16'hBEEF);
      chk("z_done", done, 1);
      chk("z_rdy", din_ready, 0);
      tick();
      chk_idle("z_end");

      // Degree 11 rejected
      start = 1'b1; instr = 8'h08; degree_in = 4'd11;
      tick();
      start = 1'b0;
      chk("e_err", err, 1);
      chk("e_busy", busy, 1);
      chk("e_wen_n", wr_en_n, 0);
      chk("e_rdy", din_ready, 0);
      tick();
      chk_idle("e_end");
      tick();
      chk("e_wen_n2", wr_en_n, 0);

      // Non-STP opcodes ignored
      for (int op = 1; op < 4; op++) begin
         start = 1'b1; instr = 8'h14 | 8'(op); degree_in = 4'd2;
         tick();
         start = 1'b0;
         chk_idle("o_a");
         tick();
         chk_idle("o_b");
      end

      // Reset mid-WR_S: poly 2, degree 3, after 2 coefficients
      start = 1'b1; instr = 8'h08; degree_in = 4'd3;
      tick();
      start = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
         din_valid = 1'b1; din = 16'h00A1 + 16'(i);
         tick();
         chk("r_addr_s", wr_addr_s, 22 + i);
      end
      din_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_idle("r_async");
      tick();
      chk_idle("r_edge");
      chk("r_addr_clr", wr_addr_s, 0);
      rst_n = 1'b1;
      tick();

      // Normal STP after reset: poly 1, degree 1 -> addresses 11, 12
      start = 1'b1; instr = 8'h04; degree_in = 4'd1;
      tick();
      start = 1'b0;
      tick();
      chk("p_wen_n", wr_en_n, 1);
      chk("p_addr_n", wr_addr_n, 1);
      chk("p_data_n", wr_data_n, 1);
      for (int i = 0; i < 2; i++) begin
         din_valid = 1'b1; din = 16'h5A00 + 16'(i);
         tick();
         chk("p_wen_s", wr_en_s, 1);
         chk("p_addr_s", wr_addr_s, 11 + i);
         chk("p_data_s", wr_data_s, 32'h5A00 + i);
         chk("p_done", done, (i == 1) ? 1 : 0);
      end
      din_valid = 1'b0;
      tick();
      chk_idle("p_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
